// File: rtl/spi_adc_responder_if.sv
// SPI pin bundle between the acquisition-path master and the ADC responder.
interface spi_adc_responder_if;
  logic SCK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic MISO_OE;

  modport master (output SCK, CS, MOSI, input MISO, MISO_OE);
  modport slave  (input SCK, CS, MOSI, output MISO, MISO_OE);
endinterface

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a 12-bit serial ADC: oversampled SCK/CS/MOSI,
// serves {PAD_BITS zeros, sample} MSB first and captures the MOSI word.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int PAD_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  spi_adc_responder_if.slave         spi,
  input  logic [DATA_W-1:0]          i_SAMPLE,
  input  logic                       i_SAMPLE_VALID,
  output logic [PAD_BITS+DATA_W-1:0] o_RX_DATA,
  output logic                       o_RX_VALID,
  output logic                       o_FRAME_ERR,
  output logic                       o_STALE,
  output logic [7:0]                 o_FRAME_CNT
);
  localparam int FB = PAD_BITS + DATA_W;
  localparam int CW = $clog2(FB + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, DONE} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign cs_rise  =  cs_s  & ~cs_d;
  assign cs_fall  = ~cs_s  &  cs_d;

  logic [DATA_W-1:0] hold;
  logic              hold_sent;
  logic [FB-1:0]     load_word;
  logic [FB-2:0]     tx_sh;
  logic [FB-2:0]     rx_sh;
  logic [CW-1:0]     bit_cnt;
  logic [FW-1:0]     flush_cnt;
  logic              miso_q, oe_q;

  // Same-cycle strobe bypasses the holding register so a just-arrived sample is served.
  assign load_word = {{PAD_BITS{1'b0}}, (i_SAMPLE_VALID ? i_SAMPLE : hold)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_IDLE;
      hold        <= '0;
      hold_sent   <= 1'b1;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      flush_cnt   <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      o_RX_DATA   <= '0;
      o_RX_VALID  <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      o_STALE     <= 1'b0;
      o_FRAME_CNT <= '0;
    end else begin
      o_RX_VALID  <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      if (i_SAMPLE_VALID) begin
        hold      <= i_SAMPLE;
        hold_sent <= 1'b0;
      end
      case (state)
        // Synchronizers reset to CS=1; wait for them to flush before trusting CS high.
        WAIT_IDLE: begin
          if (flush_cnt != FW'(SYNC_STAGES)) flush_cnt <= flush_cnt + 1'b1;
          else if (cs_s)                     state     <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            tx_sh     <= load_word[FB-2:0];
            miso_q    <= load_word[FB-1];
            o_STALE   <= i_SAMPLE_VALID ? 1'b0 : hold_sent;
            hold_sent <= 1'b1;
            bit_cnt   <= '0;
            oe_q      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            o_FRAME_ERR <= 1'b1;
            oe_q        <= 1'b0;
            miso_q      <= 1'b0;
            state       <= IDLE;
          end else if (sck_rise) begin
            rx_sh   <= {rx_sh[FB-3:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(FB - 1)) begin
              state       <= DONE;
              miso_q      <= 1'b0;
              o_RX_DATA   <= {rx_sh, mosi_s};
              o_RX_VALID  <= 1'b1;
              o_FRAME_CNT <= o_FRAME_CNT + 8'd1;
            end
          end else if (sck_fall) begin
            miso_q <= tx_sh[FB-2];
            tx_sh  <= {tx_sh[FB-3:0], 1'b0};
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            oe_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign spi.MISO    = miso_q;
  assign spi.MISO_OE = oe_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: table vectors, reset-mid-frame sequence and
// randomized frames checked against a transaction-level model.
module tb_spi_adc_responder;
  localparam int H    = 5;  // SCK half period in clk cycles (minimum legal)
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] i_SAMPLE = '0;
  logic        i_SAMPLE_VALID = 1'b0;
  logic [15:0] o_RX_DATA;
  logic        o_RX_VALID, o_FRAME_ERR, o_STALE;
  logic [7:0]  o_FRAME_CNT;

  always #5 clk = ~clk;

  spi_adc_responder_if spi();

  spi_adc_responder #(.DATA_W(12), .PAD_BITS(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi(spi),
    .i_SAMPLE(i_SAMPLE), .i_SAMPLE_VALID(i_SAMPLE_VALID),
    .o_RX_DATA(o_RX_DATA), .o_RX_VALID(o_RX_VALID), .o_FRAME_ERR(o_FRAME_ERR),
    .o_STALE(o_STALE), .o_FRAME_CNT(o_FRAME_CNT)
  );

  int n_chk = 0, n_pass = 0;
  int n_rxv = 0, n_err = 0, n_oe = 0, oe_viol = 0;

  always @(negedge clk) begin
    if (o_RX_VALID)  n_rxv++;
    if (o_FRAME_ERR) n_err++;
    if (spi.MISO_OE) n_oe++;
    if (!spi.MISO_OE && spi.MISO) oe_viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_pulse(input logic b, output logic m);
    spi.MOSI = b;
    tick(H);
    spi.SCK = 1'b1;
    m = spi.MISO;
    tick(H);
    spi.SCK = 1'b0;
  endtask

  task automatic load_sample(input logic [11:0] s);
    i_SAMPLE = s;
    i_SAMPLE_VALID = 1'b1;
    tick(1);
    i_SAMPLE_VALID = 1'b0;
  endtask

  task automatic run_frame(input logic ld, input logic byp, input logic [11:0] s,
                           input logic [15:0] mosi, input int n,
                           output logic [15:0] got, output logic [3:0] extra,
                           output int dv, output int de);
    int v0, e0;
    logic b;
    got = '0; extra = '0; v0 = n_rxv; e0 = n_err;
    if (ld) load_sample(s);
    spi.CS = 1'b0;
    // Strobe lands on the clk edge where the responder acts on the CS fall.
    if (byp) begin
      tick(SYNC);
      load_sample(s);
    end
    for (int i = 0; i < n; i++) begin
      sck_pulse((i < 16) ? mosi[15-i] : 1'b0, b);
      if (i < 16) got = {got[14:0], b};
      else        extra = {extra[2:0], b};
    end
    tick(H);
    spi.CS = 1'b1;
    spi.MOSI = 1'b0;
    tick(H + 2);
    dv = n_rxv - v0;
    de = n_err - e0;
  endtask

  typedef struct {
    logic        ld, byp;
    logic [11:0] s;
    logic [15:0] mosi;
    int          n;
    logic [15:0] e_miso, e_rx;
    logic        e_stale, e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vt[8];

  logic [15:0] got, full, eg, m_rx, mosi;
  logic [3:0]  extra;
  logic [11:0] m_hold, s, smp;
  logic        m_sent, ld, byp, est, wrapped;
  logic [7:0]  m_cnt;
  int          dv, de, n, r, q, oe0, v0, e0;
  logic        b;

  initial begin
    vt[0] = '{1'b1, 1'b0, 12'hA5C, 16'h8001, 16, 16'h0A5C, 16'h8001, 1'b0, 1'b0, 8'd1};
    vt[1] = '{1'b0, 1'b0, 12'h000, 16'h1234, 16, 16'h0A5C, 16'h1234, 1'b1, 1'b0, 8'd2};
    vt[2] = '{1'b1, 1'b0, 12'h7E1, 16'hFFFF,  7, 16'h0003, 16'h1234, 1'b0, 1'b1, 8'd2};
    vt[3] = '{1'b0, 1'b0, 12'h000, 16'h0F0F, 16, 16'h07E1, 16'h0F0F, 1'b1, 1'b0, 8'd3};
    vt[4] = '{1'b1, 1'b0, 12'hFFF, 16'hA5A5, 20, 16'h0FFF, 16'hA5A5, 1'b0, 1'b0, 8'd4};
    vt[5] = '{1'b1, 1'b0, 12'h000, 16'h0000, 16, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd5};
    vt[6] = '{1'b0, 1'b1, 12'h001, 16'hC001, 16, 16'h0001, 16'hC001, 1'b0, 1'b0, 8'd6};
    vt[7] = '{1'b0, 1'b0, 12'h000, 16'h3C3C, 16, 16'h0001, 16'h3C3C, 1'b1, 1'b0, 8'd7};

    spi.SCK = 1'b0; spi.CS = 1'b1; spi.MOSI = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    chk("rst_miso",  32'(spi.MISO), 0);
    chk("rst_oe",    32'(spi.MISO_OE), 0);
    chk("rst_rx",    32'(o_RX_DATA), 0);
    chk("rst_rxv",   32'(o_RX_VALID), 0);
    chk("rst_err",   32'(o_FRAME_ERR), 0);
    chk("rst_stale", 32'(o_STALE), 0);
    chk("rst_cnt",   32'(o_FRAME_CNT), 0);
    tick(6);

    foreach (vt[i]) begin
      run_frame(vt[i].ld, vt[i].byp, vt[i].s, vt[i].mosi, vt[i].n, got, extra, dv, de);
      chk($sformatf("v%0d_miso", i),  32'(got), 32'(vt[i].e_miso));
      chk($sformatf("v%0d_extra", i), 32'(extra), 0);
      chk($sformatf("v%0d_rx", i),    32'(o_RX_DATA), 32'(vt[i].e_rx));
      chk($sformatf("v%0d_cnt", i),   32'(o_FRAME_CNT), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_stale", i), 32'(o_STALE), 32'(vt[i].e_stale));
      chk($sformatf("v%0d_rxv", i),   32'(dv), vt[i].e_err ? 0 : 1);
      chk($sformatf("v%0d_ferr", i),  32'(de), 32'(vt[i].e_err));
      chk($sformatf("v%0d_oe", i),    32'(spi.MISO_OE), 0);
    end

    // Reset in the middle of a frame with CS held low afterwards.
    spi.CS = 1'b0;
    for (int i = 0; i < 3; i++) sck_pulse(1'b1, b);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_cnt", 32'(o_FRAME_CNT), 0);
    chk("mid_rst_rx",  32'(o_RX_DATA), 0);
    chk("mid_rst_oe",  32'(spi.MISO_OE), 0);
    oe0 = n_oe; v0 = n_rxv; e0 = n_err;
    for (int i = 0; i < 16; i++) sck_pulse(1'b1, b);
    tick(H);
    chk("wait_idle_oe",  32'(n_oe - oe0), 0);
    chk("wait_idle_rxv", 32'(n_rxv - v0), 0);
    chk("wait_idle_err", 32'(n_err - e0), 0);
    chk("wait_idle_cnt", 32'(o_FRAME_CNT), 0);
    spi.CS = 1'b1;
    tick(H + 2);
    run_frame(1'b1, 1'b0, 12'h3C5, 16'h5AA5, 16, got, extra, dv, de);
    chk("post_rst_miso",  32'(got), 32'h03C5);
    chk("post_rst_rx",    32'(o_RX_DATA), 32'h5AA5);
    chk("post_rst_cnt",   32'(o_FRAME_CNT), 1);
    chk("post_rst_stale", 32'(o_STALE), 0);
    chk("post_rst_rxv",   32'(dv), 1);

    // Randomized frames until the frame counter has wrapped.
    m_hold = 12'h3C5; m_sent = 1'b1; m_cnt = 8'd1; m_rx = 16'h5AA5; wrapped = 1'b0;
    for (int k = 0; k < 400 && (k < 300 || !wrapped); k++) begin
      r = int'($urandom_range(0, 9));
      q = int'($urandom_range(0, 9));
      ld  = (r >= 4 && r <= 6);
      byp = (r >= 7);
      s    = 12'($urandom);
      mosi = 16'($urandom);
      n = (q == 0) ? int'($urandom_range(1, 15)) : (q == 1) ? int'($urandom_range(17, 20)) : 16;
      if (ld) begin m_hold = s; m_sent = 1'b0; end
      if (byp) begin smp = s; est = 1'b0; m_hold = s; end
      else     begin smp = m_hold; est = m_sent; end
      m_sent = 1'b1;
      full = {4'h0, smp};
      if (n >= 16) begin
        m_rx = mosi;
        m_cnt = m_cnt + 8'd1;
        if (m_cnt == 8'd0) wrapped = 1'b1;
        eg = full;
      end else begin
        eg = full >> (16 - n);
      end
      run_frame(ld, byp, s, mosi, n, got, extra, dv, de);
      chk($sformatf("r%0d_miso", k),  32'(got), 32'(eg));
      chk($sformatf("r%0d_extra", k), 32'(extra), 0);
      chk($sformatf("r%0d_rx", k),    32'(o_RX_DATA), 32'(m_rx));
      chk($sformatf("r%0d_cnt", k),   32'(o_FRAME_CNT), 32'(m_cnt));
      chk($sformatf("r%0d_stale", k), 32'(o_STALE), 32'(est));
      chk($sformatf("r%0d_rxv", k),   32'(dv), (n >= 16) ? 1 : 0);
      chk($sformatf("r%0d_ferr", k),  32'(de), (n >= 16) ? 0 : 1);
    end

    chk("miso_zero_when_oe_low", 32'(oe_viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- SPI responder (slave) that emulates the 12-bit serial ADC read by the team's SPI master state machine; used for on-chip loopback and bench verification of the acquisition path.
- Oversamples SCK/CS/MOSI in the system clock domain and shifts a 16-bit frame out on MISO: PAD_BITS zeros, then the DATA_W-bit sample, MSB first.
- In the same frame it captures the MOSI word and reports frame completion, aborted frames and stale samples.

Parameters:
- DATA_W, 12, sample width in bits.
- PAD_BITS, 4, leading zero bits before the sample; FRAME_BITS = PAD_BITS + DATA_W = 16.
- SYNC_STAGES, 2, synchronizer depth on SCK, CS and MOSI (minimum 2).

Ports:
- clk  in  1  system clock; only clock in the block.
- reset  in  1  synchronous, active-high reset.
- SCK  in  1  SPI clock from master, CPOL=0; asynchronous to clk.
- CS  in  1  chip select, active low; asynchronous to clk.
- MOSI  in  1  master data in; asynchronous to clk.
- MISO  out  1  serial data to master.
- MISO_OE  out  1  MISO output enable; high only while a frame is active.
- i_SAMPLE  in  DATA_W  sample to be served.
- i_SAMPLE_VALID  in  1  one-cycle strobe that loads i_SAMPLE into the holding register.
- o_RX_DATA  out  FRAME_BITS  MOSI word from the last completed frame, first bit received in the MSB.
- o_RX_VALID  out  1  one-cycle pulse when o_RX_DATA updates.
- o_FRAME_ERR  out  1  one-cycle pulse when a frame is aborted.
- o_STALE  out  1  level; the current or last frame served a sample already sent.
- o_FRAME_CNT  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset values:
  - MISO=0, MISO_OE=0, o_RX_DATA=0, o_RX_VALID=0, o_FRAME_ERR=0, o_STALE=0, o_FRAME_CNT=0.
  - Holding register = 0, marked "sent".
  - Synchronizers load CS=1, SCK=0, MOSI=0.
- Edge detection is done on the synchronized signals against a one-cycle-delayed copy:
  - sck_rise, sck_fall, cs_fall, cs_rise.
  - Each detected edge is seen SYNC_STAGES+1 clk cycles after it occurs on the pin.
- Timing requirement on the master: SCK high and low times of at least SYNC_STAGES+3 clk periods each.
- Holding register:
  - Loads i_SAMPLE on i_SAMPLE_VALID in any state and is marked "fresh".
- State machine:
  - WAIT_IDLE (entered from reset): stay until synchronized CS=1, then go to IDLE.
    - Prevents a half-frame after a reset mid-transfer.
  - IDLE: on cs_fall, go to ACTIVE.
    - Load the shift register with {PAD_BITS zeros, sample}. If i_SAMPLE_VALID is high in the same cycle, use i_SAMPLE (bypass); otherwise use the holding register.
    - Set o_STALE = 1 if the sample used was already "sent", else 0. Then mark it "sent".
    - Set bit count = 0. Assert MISO_OE. Drive MISO with the shift-register MSB (first bit = 0 when PAD_BITS > 0).
  - ACTIVE:
    - sck_rise: shift synchronized MOSI into the rx shift register and increment bit count.
    - sck_fall: shift the tx register left and drive the next bit on MISO.
    - When bit count reaches FRAME_BITS on a sck_rise, go to DONE. On that cycle +1: o_RX_DATA takes the rx register, o_RX_VALID pulses, and o_FRAME_CNT increments.
    - cs_rise before FRAME_BITS rising edges: pulse o_FRAME_ERR, drop MISO_OE, set MISO=0, go to IDLE. o_RX_DATA, o_RX_VALID and o_FRAME_CNT are unchanged.
  - DONE:
    - Extra SCK edges are ignored; MISO is held at 0.
    - On cs_rise: drop MISO_OE, set MISO=0, go to IDLE. No error is flagged.
- Simultaneous sck and cs edges in one clk cycle:
  - cs_rise wins; the SCK edge is ignored.
  - cs_fall with sck_rise: sck_rise is ignored (CPOL=0 violation; not flagged).
- Whenever MISO_OE=0, MISO=0.
- reset has priority over everything, in every state.

Test Plan:
- Load i_SAMPLE=12'hA5C. Run a 16-clock SPI frame with MOSI=16'h8001 -> MISO bits read on SCK rising = 0000_1010_0101_1100. o_RX_DATA=16'h8001 with a 1-cycle o_RX_VALID. o_FRAME_CNT=1. o_STALE=0.
- Run a second frame without a new i_SAMPLE_VALID -> serves 12'hA5C again, o_STALE=1. Then assert i_SAMPLE_VALID with 12'h001 in the same cycle the cs_fall is detected -> that frame serves 12'h001, o_STALE=0.
- Raise CS after 7 SCK cycles -> one o_FRAME_ERR pulse. No o_RX_VALID, o_FRAME_CNT unchanged, MISO_OE=0. The next full frame completes normally.
- Assert reset while CS is low mid-frame and keep CS low after reset -> stays in WAIT_IDLE with MISO_OE=0 and no SCK response. After a CS high-then-low, a full frame works.
- Run 256 complete frames -> o_FRAME_CNT wraps to 0. Send 20 SCK pulses in one frame -> only the first 16 are captured, MISO=0 afterwards, and no o_FRAME_ERR at CS rise.
- Loopback: connect the existing SPI master to this block at the maximum legal SCK rate -> the master's 12-bit output equals i_SAMPLE for 1000 random samples.
